branch_resolve_unit: RTL and testbench

Parametrised next-generation branch/jump resolver sitting between decode and fetch. Accepts one control-flow op per cycle over a valid/ready handshake and holds a registered condition-flag set updated by the ALU. Maintains a return-address stack (RAS) for call/return and emits a registered next-PC plus redirect indication. Fetch predicts not-taken; any taken outcome is a redirect.

---
 rtl/branch_resolve_unit_if.sv | 40 ++++
 rtl/branch_resolve_unit.sv | 192 +++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Decode-to-fetch control-flow interface: op request, flag update and resolved next-PC result.
interface branch_resolve_unit_if #(
  parameter int unsigned PC_W      = 36,
  parameter int unsigned IMM_W     = 25,
  parameter int unsigned RAS_DEPTH = 8
);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       branch_jump;
  logic             link;
  logic [2:0]       branch_type;
  logic             branch_register;
  logic [IMM_W-1:0] immediate;
  logic [PC_W-1:0]  register;
  logic [PC_W-1:0]  pc;
  logic             flag_we;
  logic [5:0]       flags_in;
  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  pc_next;
  logic             taken;
  logic [CNT_W-1:0] ras_count;
  logic             ras_underflow;

  // Decode side: issues ops and flag updates, consumes results.
  modport master (
    output in_valid, branch_jump, link, branch_type, branch_register,
           immediate, register, pc, flag_we, flags_in, out_ready,
    input  in_ready, out_valid, pc_next, taken, ras_count, ras_underflow
  );

  // Resolver side.
  modport slave (
    input  in_valid, branch_jump, link, branch_type, branch_register,
           immediate, register, pc, flag_we, flags_in, out_ready,
    output in_ready, out_valid, pc_next, taken, ras_count, ras_underflow
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch/jump resolver: condition flags, return-address stack and a registered next-PC
// result behind a valid/ready handshake (latency 1, full throughput).
module branch_resolve_unit #(
  parameter int unsigned PC_W      = 36,
  parameter int unsigned IMM_W     = 25,
  parameter int unsigned RAS_DEPTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_unit_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    OP_NONE   = 2'b00,
    OP_JUMP   = 2'b01,
    OP_BRANCH = 2'b10,
    OP_RETURN = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    BT_NZ     = 3'b000,
    BT_EZ     = 3'b001,
    BT_LZ     = 3'b010,
    BT_GZ     = 3'b011,
    BT_LE     = 3'b100,
    BT_GE     = 3'b101,
    BT_ALWAYS = 3'b110,
    BT_NEVER  = 3'b111
  } btype_e;

  // Architectural state
  logic [5:0]       flags_q;
  logic             out_valid_q;
  logic [PC_W-1:0]  pc_next_q;
  logic             taken_q;
  logic             underflow_q;
  logic [PTR_W-1:0] top_q;
  logic [CNT_W-1:0] count_q;
  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];

  // Next-state values
  logic [5:0]       flags_d;
  logic             out_valid_d;
  logic [PC_W-1:0]  pc_next_d;
  logic             taken_d;
  logic             underflow_d;
  logic [PTR_W-1:0] top_d;
  logic [CNT_W-1:0] count_d;

  // Datapath
  logic             accept;
  logic [5:0]       flags_eff;
  logic [PC_W-1:0]  sext;
  logic [PC_W-1:0]  reg_term;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  fallthrough;
  logic [PC_W-1:0]  ras_top_val;
  logic             cond;
  logic [PC_W-1:0]  res_pc;
  logic             res_taken;
  logic             res_push;
  logic             res_pop;
  logic             res_underflow;
  logic             do_push;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Same-cycle flag write bypasses the flag register.
  assign flags_eff   = bus.flag_we ? bus.flags_in : flags_q;

  assign sext        = PC_W'($signed(bus.immediate));
  assign reg_term    = bus.branch_register ? bus.register : '0;
  assign target      = bus.pc + reg_term + sext;
  assign fallthrough = bus.pc + PC_W'(1);
  assign ras_top_val = ras_mem[top_q - PTR_W'(1)];

  // Condition select; flags are ordered {ge,le,gz,lz,ez,nz}.
  always_comb begin
    cond = 1'b0;
    case (bus.branch_type)
      BT_NZ:     cond = flags_eff[0];
      BT_EZ:     cond = flags_eff[1];
      BT_LZ:     cond = flags_eff[2];
      BT_GZ:     cond = flags_eff[3];
      BT_LE:     cond = flags_eff[4];
      BT_GE:     cond = flags_eff[5];
      BT_ALWAYS: cond = 1'b1;
      BT_NEVER:  cond = 1'b0;
      default:   cond = 1'b0;
    endcase
  end

  // Resolution of the presented op, independent of whether it is accepted.
  always_comb begin
    res_pc        = fallthrough;
    res_taken     = 1'b0;
    res_push      = 1'b0;
    res_pop       = 1'b0;
    res_underflow = 1'b0;
    case (bus.branch_jump)
      OP_NONE: ;
      OP_JUMP: begin
        res_pc    = target;
        res_taken = 1'b1;
        res_push  = bus.link;
      end
      OP_BRANCH: begin
        if (cond) begin
          res_pc    = target;
          res_taken = 1'b1;
        end
      end
      OP_RETURN: begin
        if (count_q != '0) begin
          res_pc    = ras_top_val;
          res_taken = 1'b1;
          res_pop   = 1'b1;
        end else begin
          res_underflow = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign do_push = accept && res_push;

  // Next-state: result, RAS pointer/count and flags.
  always_comb begin
    flags_d     = bus.flag_we ? bus.flags_in : flags_q;
    out_valid_d = out_valid_q;
    pc_next_d   = pc_next_q;
    taken_d     = taken_q;
    underflow_d = underflow_q;
    top_d       = top_q;
    count_d     = count_q;
    if (accept) begin
      out_valid_d = 1'b1;
      pc_next_d   = res_pc;
      taken_d     = res_taken;
      underflow_d = underflow_q | res_underflow;
      if (res_push) begin
        // A full stack overwrites its oldest entry, which sits at top.
        top_d = top_q + PTR_W'(1);
        if (count_q != CNT_W'(RAS_DEPTH)) begin
          count_d = count_q + CNT_W'(1);
        end
      end else if (res_pop) begin
        top_d   = top_q - PTR_W'(1);
        count_d = count_q - CNT_W'(1);
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      pc_next_q   <= '0;
      taken_q     <= 1'b0;
      underflow_q <= 1'b0;
      top_q       <= '0;
      count_q     <= '0;
    end else begin
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      pc_next_q   <= pc_next_d;
      taken_q     <= taken_d;
      underflow_q <= underflow_d;
      top_q       <= top_d;
      count_q     <= count_d;
    end
  end

  // Stack storage carries no reset; only the pointer and count are meaningful.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      ras_mem[top_q] <= fallthrough;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.pc_next       = pc_next_q;
  assign bus.taken         = taken_q;
  assign bus.ras_count     = count_q;
  assign bus.ras_underflow = underflow_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed plan cases plus randomized ops
// against a queue-based reference model.
module tb_branch_resolve_unit;
  localparam int unsigned PC_W      = 36;
  localparam int unsigned IMM_W     = 25;
  localparam int unsigned RAS_DEPTH = 8;
  localparam int unsigned CNT_W     = $clog2(RAS_DEPTH) + 1;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic             tk;
    logic [CNT_W-1:0] cnt;
    logic             uf;
  } exp_t;

  typedef struct {
    logic             r;
    logic             v;
    logic [1:0]       bj;
    logic             lk;
    logic [2:0]       bt;
    logic             br;
    logic [IMM_W-1:0] imm;
    logic [PC_W-1:0]  rg;
    logic [PC_W-1:0]  p;
    logic             fwe;
    logic [5:0]       fl;
    logic             ordy;
  } stim_t;

  logic clk;
  logic rst;

  branch_resolve_unit_if #(.PC_W(PC_W), .IMM_W(IMM_W), .RAS_DEPTH(RAS_DEPTH)) bus ();

  branch_resolve_unit #(.PC_W(PC_W), .IMM_W(IMM_W), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors = 0;
  int errors  = 0;

  exp_t            sb[$];
  logic [5:0]      m_flags;
  logic [PC_W-1:0] m_ras[$];
  logic            m_uf;
  logic            m_pending;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.r = 1'b0; s.v = 1'b0; s.bj = 2'b00; s.lk = 1'b0; s.bt = 3'b000; s.br = 1'b0;
    s.imm = '0; s.rg = '0; s.p = '0; s.fwe = 1'b0; s.fl = '0; s.ordy = 1'b1;
    return s;
  endfunction

  function automatic stim_t mk_op(logic [1:0] bj, logic [PC_W-1:0] p, logic [IMM_W-1:0] imm);
    stim_t s = idle();
    s.v = 1'b1; s.bj = bj; s.p = p; s.imm = imm;
    return s;
  endfunction

  // Drive one cycle; the model decides acceptance and the expected result independently.
  task automatic step(input stim_t s);
    logic [5:0]      eff;
    logic            exp_ready, acc, cnd, tk, push, pop, uf_set;
    logic [PC_W-1:0] fall, tgt, res;
    longint          t;
    exp_t            e;
    rst                 = s.r;
    bus.in_valid        = s.v;
    bus.branch_jump     = s.bj;
    bus.link            = s.lk;
    bus.branch_type     = s.bt;
    bus.branch_register = s.br;
    bus.immediate       = s.imm;
    bus.register        = s.rg;
    bus.pc              = s.p;
    bus.flag_we         = s.fwe;
    bus.flags_in        = s.fl;
    bus.out_ready       = s.ordy;
    #1;
    exp_ready = !m_pending || s.ordy;
    if (!s.r) begin
      check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
      check("out_valid", 64'(bus.out_valid), 64'(m_pending));
      check("ras_count", 64'(bus.ras_count), 64'(m_ras.size()));
      check("ras_underflow", 64'(bus.ras_underflow), 64'(m_uf));
      if (m_pending && sb.size() > 0) begin
        check("held_pc_next", 64'(bus.pc_next), 64'(sb[0].pc));
        check("held_taken", 64'(bus.taken), 64'(sb[0].tk));
      end
    end
    acc  = s.v && exp_ready && !s.r;
    eff  = s.fwe ? s.fl : m_flags;
    fall = PC_W'(longint'(s.p) + 64'sd1);
    t    = longint'(s.p) + (s.br ? longint'(s.rg) : 64'sd0) + longint'($signed(s.imm));
    tgt  = PC_W'(t);
    cnd  = (s.bt == 3'd6) ? 1'b1 : (s.bt == 3'd7) ? 1'b0 : eff[s.bt];
    res = fall; tk = 1'b0; push = 1'b0; pop = 1'b0; uf_set = 1'b0;
    case (s.bj)
      2'b01: begin res = tgt; tk = 1'b1; push = s.lk; end
      2'b10: if (cnd) begin res = tgt; tk = 1'b1; end
      2'b11: if (m_ras.size() > 0) begin res = m_ras[$]; tk = 1'b1; pop = 1'b1; end
             else uf_set = 1'b1;
      default: ;
    endcase
    @(posedge clk);
    if (s.r) begin
      m_flags = '0; m_ras.delete(); m_uf = 1'b0; m_pending = 1'b0; sb.delete();
    end else begin
      if (s.fwe) m_flags = s.fl;
      if (acc) begin
        if (push) begin
          m_ras.push_back(fall);
          if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end else if (pop) begin
          void'(m_ras.pop_back());
        end
        m_uf = m_uf | uf_set;
        e.pc = res; e.tk = tk; e.cnt = CNT_W'(m_ras.size()); e.uf = m_uf;
        sb.push_back(e);
        m_pending = 1'b1;
      end else if (s.ordy) begin
        m_pending = 1'b0;
      end
    end
    #1;
  endtask

  // Monitor: every result fetch consumes is compared against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_result: got pc_next %0h with empty scoreboard", bus.pc_next);
      end else begin
        e = sb.pop_front();
        check("pc_next", 64'(bus.pc_next), 64'(e.pc));
        check("taken", 64'(bus.taken), 64'(e.tk));
        check("result_ras_count", 64'(bus.ras_count), 64'(e.cnt));
        check("result_underflow", 64'(bus.ras_underflow), 64'(e.uf));
      end
    end
  end

  initial begin
    stim_t s;
    m_flags = '0; m_uf = 1'b0; m_pending = 1'b0;
    s = idle(); s.r = 1'b1;
    step(s); step(s);
    step(idle());
    check("reset_pc_next", 64'(bus.pc_next), 64'h0);
    check("reset_taken", 64'(bus.taken), 64'h0);

    // Conditional branch on ez with same-cycle flag bypass and negative offset
    s = mk_op(2'b10, PC_W'(36'h100), IMM_W'(-4)); s.bt = 3'b001; s.fwe = 1'b1; s.fl = 6'b000010;
    step(s);
    s.fl = 6'b000000;
    step(s);

    // Register-relative jump and PC wrap
    s = mk_op(2'b01, PC_W'(36'h10), IMM_W'(5)); s.br = 1'b1; s.rg = PC_W'(36'h200);
    step(s);
    step(mk_op(2'b01, PC_W'(36'hF_FFFF_FFFF), IMM_W'(2)));

    // Nine calls saturate the stack, nine returns drain it and underflow once
    for (int i = 0; i < 9; i++) begin
      s = mk_op(2'b01, PC_W'(i), IMM_W'(32'h40)); s.lk = 1'b1;
      step(s);
    end
    for (int i = 0; i < 9; i++) step(mk_op(2'b11, PC_W'(36'h50 + i), '0));

    // Backpressure: result held three cycles while a call waits
    s = mk_op(2'b01, PC_W'(36'h300), IMM_W'(8)); s.lk = 1'b1; s.ordy = 1'b0;
    step(s);
    s.p = PC_W'(36'h400);
    for (int i = 0; i < 3; i++) step(s);
    s.ordy = 1'b1;
    step(s);
    step(idle());

    // Reset wins over a concurrent call
    s = mk_op(2'b01, PC_W'(36'h500), IMM_W'(1)); s.lk = 1'b1; s.r = 1'b1;
    step(s);
    step(idle());

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      s.r    = ($urandom_range(0, 199) == 0);
      s.v    = ($urandom_range(0, 9) < 8);
      s.bj   = 2'($urandom_range(0, 3));
      s.lk   = 1'($urandom_range(0, 1));
      s.bt   = 3'($urandom_range(0, 7));
      s.br   = 1'($urandom_range(0, 1));
      s.imm  = IMM_W'($urandom());
      s.rg   = PC_W'({$urandom(), $urandom()});
      s.p    = PC_W'({$urandom(), $urandom()});
      s.fwe  = 1'($urandom_range(0, 1));
      s.fl   = 6'($urandom());
      s.ordy = ($urandom_range(0, 9) < 7);
      step(s);
    end

    for (int i = 0; i < 4; i++) step(idle());
    check("scoreboard_drained", 64'(sb.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
